// File: rtl/addsub_pipe_acc_if.sv
// Operand/result handshake bundle for addsub_pipe_acc.
// The producer/consumer side uses master; the block uses slave.
interface addsub_pipe_acc_if #(
   parameter int N = 8,
   parameter int M = 4
) ();
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [M-1:0] b;
   logic [1:0]   op;
   logic         sat;
   logic         clr;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] s;
   logic         ovf;
   logic         ovf_sticky;
   logic [N-1:0] acc;

   modport master (
      output in_valid, a, b, op, sat, clr, out_ready,
      input  in_ready, out_valid, s, ovf, ovf_sticky, acc
   );

   modport slave (
      input  in_valid, a, b, op, sat, clr, out_ready,
      output in_ready, out_valid, s, ovf, ovf_sticky, acc
   );
endinterface

// File: rtl/addsub_pipe_acc.sv
// Two-stage pipelined two's-complement add/subtract with optional saturation,
// an internal accumulator and a sticky overflow flag.
module addsub_pipe_acc #(
   parameter int N           = 8,
   parameter int M           = 4,
   parameter bit SAT_DEFAULT = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   addsub_pipe_acc_if.slave bus
);

   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

   // Stage 1 operand register
   logic         s1_valid;
   logic [N-1:0] s1_a;
   logic [N-1:0] s1_b;
   logic         s1_cin;
   logic [1:0]   s1_op;
   logic         s1_sat;

   // Stage 2 / architectural state
   logic         out_valid_q;
   logic [N-1:0] s_q;
   logic         ovf_q;
   logic         ovf_sticky_q;
   logic [N-1:0] acc_q;
   logic         sat_reg;

   logic         in_xfer;
   logic         s2_load;
   logic [N-1:0] b_ext;
   logic [N-1:0] left;
   logic [N:0]   full_sum;
   logic [N-1:0] low_sum;
   logic         ovf_c;
   logic [N-1:0] s_final;

   // Sized signed cast sign-extends b; with M == N it is the identity.
   assign b_ext   = N'($signed(bus.b));

   assign s2_load = s1_valid & (~out_valid_q | bus.out_ready);
   assign in_xfer = bus.in_valid & bus.in_ready;

   assign bus.in_ready   = ~s1_valid | s2_load;
   assign bus.out_valid  = out_valid_q;
   assign bus.s          = s_q;
   assign bus.ovf        = ovf_q;
   assign bus.ovf_sticky = ovf_sticky_q;
   assign bus.acc        = acc_q;

   // NOTE: every always_comb output is given a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      left     = s1_op[1] ? acc_q : s1_a;
      full_sum = {1'b0, left} + {1'b0, s1_b} + (N+1)'(s1_cin);
      // Carry into the MSB comes from the sum of the lower N-1 bits.
      low_sum  = {1'b0, left[N-2:0]} + {1'b0, s1_b[N-2:0]} + N'(s1_cin);
      ovf_c    = low_sum[N-1] ^ full_sum[N];
      s_final  = full_sum[N-1:0];
      if ((s1_sat | sat_reg) && ovf_c)
         s_final = full_sum[N-1] ? SAT_MAX : SAT_MIN;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         out_valid_q  <= 1'b0;
         s_q          <= '0;
         ovf_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
         acc_q        <= '0;
         sat_reg      <= SAT_DEFAULT;
      end else begin
         if (bus.in_ready)
            s1_valid <= bus.in_valid;

         if (s2_load) begin
            out_valid_q <= 1'b1;
            s_q         <= s_final;
            ovf_q       <= ovf_c;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (in_xfer && bus.op == 2'b11 && bus.b == '0)
            sat_reg <= bus.sat;

         // A coincident accumulate load takes priority over clr.
         if (s2_load && s1_op[1])
            acc_q <= s_final;
         else if (bus.clr)
            acc_q <= '0;

         if (s2_load && ovf_c)
            ovf_sticky_q <= 1'b1;
         else if (bus.clr)
            ovf_sticky_q <= 1'b0;
      end
   end

   // NOTE: operand registers carry no reset; s1_valid gates every use of them.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         s1_a   <= bus.a;
         s1_b   <= bus.op[0] ? ~b_ext : b_ext;
         s1_cin <= bus.op[0];
         s1_op  <= bus.op;
         s1_sat <= bus.sat;
      end
   end

endmodule

// File: tb/tb_addsub_pipe_acc.sv
// Directed-vector bench for addsub_pipe_acc with N=8, M=4.
module tb_addsub_pipe_acc;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   addsub_pipe_acc_if #(.N(8), .M(4)) bus ();

   addsub_pipe_acc #(.N(8), .M(4), .SAT_DEFAULT(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Single beat with out_ready=1; waits a bounded time for the result.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] av,
                        input logic [3:0] bv, input logic sv,
                        input logic [7:0] es, input logic eo);
      int n;
      @(negedge clk);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      bus.in_valid  = 1'b1;
      bus.op        = o;
      bus.a         = av;
      bus.b         = bv;
      bus.sat       = sv;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      check({tag, "_s"}, bus.s, es);
      check({tag, "_ovf"}, bus.ovf, eo);
   endtask

   logic [7:0] got_q[$];
   int         cyc_q[$];
   logic       c_taken;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = 2'b00;
      bus.sat       = 1'b0;
      bus.clr       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_s", bus.s, 8'h00);
      check("rst_ovf", bus.ovf, 1'b0);
      check("rst_sticky", bus.ovf_sticky, 1'b0);
      check("rst_acc", bus.acc, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", bus.in_ready, 1'b1);

      // Plain add/sub vectors
      do_op("add_neg_b", 2'b00, 8'h00, 4'b1000, 1'b0, 8'hF8, 1'b0);
      do_op("add_pos",   2'b00, 8'h64, 4'b0111, 1'b0, 8'h6B, 1'b0);
      check("sticky_clean", bus.ovf_sticky, 1'b0);
      do_op("pov_wrap",  2'b00, 8'h7D, 4'd7, 1'b0, 8'h84, 1'b1);
      check("pov_wrap_sticky", bus.ovf_sticky, 1'b1);
      do_op("pov_sat",   2'b00, 8'h7D, 4'd7, 1'b1, 8'h7F, 1'b1);
      check("pov_sat_sticky", bus.ovf_sticky, 1'b1);
      do_op("nov_sat",   2'b01, 8'h80, 4'd1, 1'b1, 8'h80, 1'b1);
      do_op("nov_wrap",  2'b01, 8'h80, 4'd1, 1'b0, 8'h7F, 1'b1);
      do_op("min_sub_m1", 2'b01, 8'h80, 4'hF, 1'b0, 8'h81, 1'b0);
      check("acc_untouched", bus.acc, 8'h00);

      // Saturation-enable register via op=11, b=0
      do_op("satreg_set", 2'b11, 8'h55, 4'h0, 1'b1, 8'h00, 1'b0);
      do_op("satreg_use", 2'b00, 8'h7D, 4'd7, 1'b0, 8'h7F, 1'b1);
      do_op("satreg_clr", 2'b11, 8'h55, 4'h0, 1'b0, 8'h00, 1'b0);
      do_op("satreg_off", 2'b00, 8'h7D, 4'd7, 1'b0, 8'h84, 1'b1);

      // clr then three back-to-back accumulate beats
      @(negedge clk);
      bus.clr       = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      check("clr_sticky", bus.ovf_sticky, 1'b0);
      check("clr_acc", bus.acc, 8'h00);
      bus.in_valid = 1'b1;
      bus.op       = 2'b10;
      bus.a        = 8'hAA;
      bus.b        = 4'd5;
      bus.sat      = 1'b0;
      got_q.delete();
      cyc_q.delete();
      for (int k = 0; k < 8; k++) begin
         if (k == 3) bus.in_valid = 1'b0;
         #1;
         if (bus.out_valid) begin
            got_q.push_back(bus.s);
            cyc_q.push_back(k);
         end
         @(negedge clk);
      end
      check("accum_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("accum_0", got_q[0], 8'h05);
         check("accum_1", got_q[1], 8'h0A);
         check("accum_2", got_q[2], 8'h0F);
         check("accum_gap01", cyc_q[1] - cyc_q[0], 1);
         check("accum_gap12", cyc_q[2] - cyc_q[1], 1);
      end
      check("accum_final", bus.acc, 8'h0F);

      // Backpressure: out_ready held low from the start
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.op        = 2'b00;
      bus.a         = 8'h01;
      bus.b         = 4'd1;
      @(negedge clk);
      bus.a = 8'h10;
      bus.b = 4'd2;
      @(negedge clk);
      bus.a = 8'h20;
      bus.b = 4'd3;
      #1;
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_s", bus.s, 8'h02);
      repeat (2) @(negedge clk);
      check("bp_hold_s", bus.s, 8'h02);
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_ready", bus.in_ready, 1'b0);
      bus.out_ready = 1'b1;
      got_q.delete();
      c_taken = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (bus.out_valid) got_q.push_back(bus.s);
         if (bus.in_valid && bus.in_ready) c_taken = 1'b1;
         @(negedge clk);
         if (c_taken) bus.in_valid = 1'b0;
      end
      check("bp_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("bp_drain_0", got_q[0], 8'h02);
         check("bp_drain_1", got_q[1], 8'h12);
         check("bp_drain_2", got_q[2], 8'h23);
      end

      // Reset mid-stream
      do_op("pre_rst_ovf", 2'b00, 8'h7D, 4'd7, 1'b0, 8'h84, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 2'b10;
      bus.b        = 4'd3;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", bus.out_valid, 1'b0);
      check("mid_rst_acc", bus.acc, 8'h00);
      check("mid_rst_sticky", bus.ovf_sticky, 1'b0);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      @(negedge clk);
      check("post_rst_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      check("post_rst_no_partial", bus.out_valid, 1'b0);
      do_op("post_rst_op", 2'b00, 8'h7D, 4'd7, 1'b0, 8'h84, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
